slide_scan_ctrl: RTL and testbench

SLIDE_SCAN_CTRL -- requirements
Module: slide_scan_ctrl

---
 rtl/slide_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_slide_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/slide_scan_ctrl.sv
// Sliding-piece move scanner: walks up to eight ray directions from a rook, bishop or
// queen square, probing the board one square per cycle, and reports per-direction reach.
module slide_scan_ctrl #(
   parameter int MAXDIST = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      row,
   input  logic [2:0]      column,
   input  logic            color,
   input  logic [1:0]      pieceType,
   output logic [2:0]      sqRow,
   output logic [2:0]      sqCol,
   input  logic [2:0]      sqData,
   output logic            busy,
   output logic            done,
   output logic [7:0][2:0] allow
);

   localparam int SW = $clog2(MAXDIST + 2);

   // Direction membership per ray axis, indexed by dir (0=Up ... 7=UpLeft).
   localparam logic [7:0] UP_DIRS    = 8'b1000_0011;
   localparam logic [7:0] DOWN_DIRS  = 8'b0011_1000;
   localparam logic [7:0] RIGHT_DIRS = 8'b0000_1110;
   localparam logic [7:0] LEFT_DIRS  = 8'b1110_0000;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      dir_reg, dir_next;
   logic [SW-1:0]   step_reg, step_next;
   logic [2:0]      row_reg, col_reg;
   logic            color_reg;
   logic [7:0]      mask_reg, mask_next;
   logic [7:0][2:0] allow_reg;

   logic            capture_en;
   logic            clear_allow;
   logic            dir_end;
   logic [2:0]      wr_val;
   logic [7:0]      wr_en;
   logic            has_next;
   logic [2:0]      next_dir;
   logic [3:0]      step4;
   logic [3:0]      tgt_row, tgt_col;
   logic            off_board;
   logic            over_max;
   logic            unused_king;

   // The king bit does not matter here: an enemy king is captured like any other piece.
   assign unused_king = sqData[2];

   always_comb begin
      mask_next = 8'h00;
      case (pieceType)
         2'd0:    mask_next = 8'b0101_0101;
         2'd1:    mask_next = 8'b1010_1010;
         2'd2:    mask_next = 8'hFF;
         default: mask_next = 8'h00;
      endcase
   end

   // Target square in 4-bit signed space; anything outside 0..7 sets bit 3.
   assign step4 = 4'(step_reg);

   always_comb begin
      tgt_row = {1'b0, row_reg};
      tgt_col = {1'b0, col_reg};
      if (UP_DIRS[dir_reg])
         tgt_row = {1'b0, row_reg} - step4;
      else if (DOWN_DIRS[dir_reg])
         tgt_row = {1'b0, row_reg} + step4;
      if (RIGHT_DIRS[dir_reg])
         tgt_col = {1'b0, col_reg} + step4;
      else if (LEFT_DIRS[dir_reg])
         tgt_col = {1'b0, col_reg} - step4;
   end

   assign off_board = tgt_row[3] | tgt_col[3];
   assign over_max  = (step_reg > SW'(MAXDIST));

   // Lowest enabled direction above the current one.
   always_comb begin
      has_next = 1'b0;
      next_dir = dir_reg;
      for (int i = 7; i >= 0; i--) begin
         if (mask_reg[i] && (i > int'(dir_reg))) begin
            has_next = 1'b1;
            next_dir = 3'(i);
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      dir_next    = dir_reg;
      step_next   = step_reg;
      capture_en  = 1'b0;
      clear_allow = 1'b0;
      dir_end     = 1'b0;
      wr_val      = 3'd0;
      sqRow       = 3'd0;
      sqCol       = 3'd0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               capture_en  = 1'b1;
               clear_allow = 1'b1;
               step_next   = SW'(1);
               if (pieceType == 2'd3) begin
                  dir_next   = 3'd0;
                  state_next = DONE;
               end else begin
                  dir_next   = (pieceType == 2'd1) ? 3'd1 : 3'd0;
                  state_next = SCAN;
               end
            end
         end
         SCAN: begin
            if (over_max) begin
               dir_end = 1'b1;
               wr_val  = 3'(MAXDIST);
            end else if (off_board) begin
               dir_end = 1'b1;
               wr_val  = 3'(step_reg - SW'(1));
            end else begin
               sqRow = tgt_row[2:0];
               sqCol = tgt_col[2:0];
               if (!sqData[0]) begin
                  step_next = step_reg + SW'(1);
               end else if (sqData[1] == color_reg) begin
                  dir_end = 1'b1;
                  wr_val  = 3'(step_reg - SW'(1));
               end else begin
                  dir_end = 1'b1;
                  wr_val  = 3'(step_reg);
               end
            end
            if (dir_end) begin
               step_next = SW'(1);
               if (has_next)
                  dir_next = next_dir;
               else
                  state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         dir_reg   <= 3'd0;
         step_reg  <= SW'(1);
         row_reg   <= 3'd0;
         col_reg   <= 3'd0;
         color_reg <= 1'b0;
         mask_reg  <= 8'h00;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         step_reg  <= step_next;
         if (capture_en) begin
            row_reg   <= row;
            col_reg   <= column;
            color_reg <= color;
            mask_reg  <= mask_next;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_wr_en
         assign wr_en[gi] = dir_end && (dir_reg == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         allow_reg <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (clear_allow)
               allow_reg[i] <= 3'd0;
            else if (wr_en[i])
               allow_reg[i] <= wr_val;
         end
      end
   end

   assign allow = allow_reg;
   assign busy  = (state_reg != IDLE);
   assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_slide_scan_ctrl.sv
// Directed bench for slide_scan_ctrl: a board model answers reads, expected results
// are queued when a scan is launched and compared when done pulses.
module tb_slide_scan_ctrl;

   typedef logic [7:0][2:0] allow_t;
   typedef struct {
      allow_t allow;
      int     lat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [2:0]      row = 3'd0;
   logic [2:0]      column = 3'd0;
   logic            color = 1'b0;
   logic [1:0]      pieceType = 2'd0;
   logic [2:0]      sqRow, sqCol;
   logic [2:0]      sqData;
   logic            busy, done;
   allow_t          allow;

   logic [2:0]      board [8][8];
   exp_t            sb [$];
   int              checks = 0;
   int              failures = 0;

   always #5 clk = ~clk;

   assign sqData = board[sqRow][sqCol];

   slide_scan_ctrl #(.MAXDIST(7)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .row(row), .column(column),
      .color(color), .pieceType(pieceType), .sqRow(sqRow), .sqCol(sqCol),
      .sqData(sqData), .busy(busy), .done(done), .allow(allow)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_board();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            board[r][c] = 3'd0;
   endtask

   // Reference: walk each enabled ray over the board array.
   task automatic model(input int r, input int c, input int col, input int pt,
                        output allow_t a, output int lat);
      int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
      int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
      a = '0;
      lat = 1;
      for (int d = 0; d < 8; d++) begin
         bit en;
         int s;
         en = (pt == 2) || (pt == 0 && d % 2 == 0) || (pt == 1 && d % 2 == 1);
         if (en) begin
            s = 1;
            while (1) begin
               int nr, nc;
               nr = r + dr[d] * s;
               nc = c + dc[d] * s;
               if (s > 7) begin a[d] = 3'd7; break; end
               if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin a[d] = 3'(s - 1); break; end
               if (board[nr][nc][0] == 1'b0) begin s++; continue; end
               if (board[nr][nc][1] == col[0]) a[d] = 3'(s - 1);
               else a[d] = 3'(s);
               break;
            end
            lat += s;
         end
      end
   endtask

   task automatic run_scan(input string tag, input int r, input int c, input int col,
                           input int pt, input allow_t exp_allow, input int exp_lat,
                           input bit poke);
      exp_t e;
      int edges;
      bit seen;
      e.allow = exp_allow;
      e.lat = exp_lat;
      row = 3'(r); column = 3'(c); color = col[0]; pieceType = 2'(pt); start = 1'b1;
      sb.push_back(e);
      edges = 0;
      seen = 1'b0;
      while (!seen && edges < 200) begin
         @(posedge clk);
         edges++;
         #1;
         if (edges == 1) start = 1'b0;
         if (poke && edges == 3) begin
            start = 1'b1; row = 3'd0; column = 3'd0; pieceType = 2'd0;
         end
         if (poke && edges == 4) start = 1'b0;
         if (done) seen = 1'b1;
      end
      e = sb.pop_front();
      if (!seen) begin
         chk({tag, "_done_timeout"}, 0, 1);
      end else begin
         chk({tag, "_latency"}, edges, e.lat);
         for (int d = 0; d < 8; d++)
            chk($sformatf("%s_allow%0d", tag, d), int'(allow[d]), int'(e.allow[d]));
         @(posedge clk); #1;
         chk({tag, "_done_pulse_end"}, int'(done), 0);
         chk({tag, "_idle_busy"}, int'(busy), 0);
         chk({tag, "_idle_addr"}, int'({sqRow, sqCol}), 0);
         chk({tag, "_allow_hold"}, int'(allow == e.allow), 1);
      end
      @(negedge clk);
   endtask

   initial begin
      allow_t ea;
      int el;
      int done_cnt;

      clear_board();
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_allow", int'(allow), 0);
      chk("rst_addr", int'({sqRow, sqCol}), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Rook at the corner of an empty board.
      ea = '0; ea[2] = 3'd7; ea[4] = 3'd7;
      run_scan("rook_corner", 0, 0, 0, 0, ea, 19, 1'b0);

      // Queen in the middle of an empty board.
      ea = '0;
      ea[0] = 3'd3; ea[1] = 3'd3; ea[2] = 3'd4; ea[3] = 3'd4;
      ea[4] = 3'd4; ea[5] = 3'd3; ea[6] = 3'd3; ea[7] = 3'd3;
      run_scan("queen_center", 3, 3, 0, 2, ea, 36, 1'b0);

      // White bishop blocked by a friend and able to capture an enemy.
      clear_board();
      board[5][4] = 3'b001;
      board[6][1] = 3'b011;
      ea = '0; ea[1] = 3'd1; ea[7] = 3'd1;
      run_scan("bishop_block", 7, 2, 0, 1, ea, 6, 1'b0);

      // Enemy king is captured like any piece; black rook, white pieces around.
      clear_board();
      board[4][6] = 3'b101;
      board[1][4] = 3'b001;
      board[4][0] = 3'b011;
      model(4, 4, 1, 0, ea, el);
      run_scan("rook_king", 4, 4, 1, 0, ea, el, 1'b0);

      // Invalid piece type skips straight to DONE.
      clear_board();
      ea = '0;
      run_scan("invalid", 2, 5, 1, 3, ea, 1, 1'b0);

      // Start pulsed mid-scan must be ignored.
      ea = '0;
      ea[0] = 3'd3; ea[1] = 3'd3; ea[2] = 3'd4; ea[3] = 3'd4;
      ea[4] = 3'd4; ea[5] = 3'd3; ea[6] = 3'd3; ea[7] = 3'd3;
      run_scan("busy_start", 3, 3, 0, 2, ea, 36, 1'b1);

      // Randomly populated board, queen of random color.
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            board[r][c] = ($urandom_range(0, 3) == 0) ?
                          {1'b0, 1'($urandom_range(0, 1)), 1'b1} : 3'd0;
      board[2][5] = 3'd0;
      begin
         int qc;
         qc = int'($urandom_range(0, 1));
         model(2, 5, qc, 2, ea, el);
         run_scan("queen_random", 2, 5, qc, 2, ea, el, 1'b0);
      end

      // Reset in the middle of a queen scan.
      clear_board();
      row = 3'd3; column = 3'd3; color = 1'b0; pieceType = 2'd2; start = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) done_cnt++;
      end
      chk("mid_busy_before_rst", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_allow", int'(allow), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      chk("mid_rst_no_done", done_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ea = '0;
      ea[0] = 3'd3; ea[1] = 3'd3; ea[2] = 3'd4; ea[3] = 3'd4;
      ea[4] = 3'd4; ea[5] = 3'd3; ea[6] = 3'd3; ea[7] = 3'd3;
      run_scan("after_rst", 3, 3, 0, 2, ea, 36, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
